// File: rtl/mem_access_unit.sv
// Byte-addressed MIPS load/store front end for a word-wide data memory (big-endian lanes).
// Define MEM_ACCESS_RANGE_CHECK_EN to fault on word indices >= MEM_WORDS instead of wrapping them.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WRITE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        req_fault;
    logic [31:0] word_idx;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            2'b10:   req_fault = 1'b1;
            2'b01:   req_fault = req_addr[0];
            2'b11:   req_fault = (req_addr[1:0] != 2'b00);
            default: req_fault = 1'b0;
        endcase
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
            req_fault = 1'b1;
        end
`endif
    end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign word_idx = {2'b00, addr_q[31:2]};
`else
    // Wrap by masking: MEM_WORDS is expected to be a power of two.
    assign word_idx = {2'b00, addr_q[31:2]} & 32'(MEM_WORDS - 1);
`endif

    // Big-endian: byte offset 0 is the most significant lane.
    assign byte_sh = {~addr_q[1:0], 3'b000};
    assign half_sh = {~addr_q[1], 4'b0000};
    assign lane_b  = mem_out[byte_sh +: 8];
    assign lane_h  = mem_out[half_sh +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = mem_out;
        endcase
        if (size_q == 2'b00) begin
            merged_word = (mem_out & ~(32'h0000_00FF << byte_sh))
                        | ({24'h0, wdata_q[7:0]} << byte_sh);
        end else begin
            merged_word = (mem_out & ~(32'h0000_FFFF << half_sh))
                        | ({16'h0, wdata_q[15:0]} << half_sh);
        end
    end

    always_comb begin
        state_d          = state_q;
        wr_d             = wr_q;
        size_d           = size_q;
        uns_d            = uns_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        merged_d         = merged_q;
        rdata_d          = rdata_q;
        fault_d          = fault_q;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_fault) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_address = word_idx;
                if (!wr_q) begin
                    mem_read_enable = 1'b1;
                    rdata_d         = load_data;
                    fault_d         = 1'b0;
                    state_d         = RESP;
                end else if (size_q == 2'b11) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = wdata_q;
                    rdata_d          = '0;
                    fault_d          = 1'b0;
                    state_d          = RESP;
                end else begin
                    mem_read_enable = 1'b1;
                    merged_d        = merged_word;
                    state_d         = MERGE_WRITE;
                end
            end
            MERGE_WRITE: begin
                mem_address      = word_idx;
                mem_write_enable = 1'b1;
                mem_write_data   = merged_q;
                rdata_d          = '0;
                fault_d          = 1'b0;
                state_d          = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset held low in ACCESS/MERGE_WRITE must stop the write at the coming edge.
        if (!reset_n) begin
            mem_address      = '0;
            mem_write_data   = '0;
            mem_write_enable = 1'b0;
            mem_read_enable  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan cases plus random traffic against a word-array model.
// Honours MEM_ACCESS_RANGE_CHECK_EN the same way the design does.
module tb_mem_access_unit;

    localparam int unsigned MW = 128;
    localparam int unsigned IW = $clog2(MW);

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_out;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int unsigned last_wait = 0;

    mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_out          (mem_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Data memory seen by the DUT: combinational read, write on the rising edge.
    initial begin
        for (int unsigned i = 0; i < MW; i++) mem[i] = '0;
        forever begin
            @(posedge clock);
            if (mem_write_enable && mem_address < MW) mem[mem_address[IW-1:0]] <= mem_write_data;
        end
    end
    assign mem_out = (mem_address < MW) ? mem[mem_address[IW-1:0]] : 32'h0;

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. With keep set, req_valid stays high with junk fields while
    // busy, and the caller must issue the next request immediately.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input bit keep);
        bit          e_fault;
        int unsigned widx, idx, sh, e_lat, e_rd, e_wr, e_wcyc;
        int unsigned lat, n_rd, n_wr, w_cyc, wt;
        logic [31:0] old, lane, e_rdata, e_word, w_addr, w_data, r_addr;

        widx    = a >> 2;
        e_fault = (sz == 2'b10) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b11 && a % 4 != 0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        if (widx >= MW) e_fault = 1'b1;
        idx = widx;
`else
        idx = widx % MW;
`endif
        old     = (idx < MW) ? ref_mem[idx[IW-1:0]] : 32'h0;
        e_word  = old;
        e_rdata = '0;
        case (sz)
            2'b00: begin
                sh      = 8 * (3 - a % 4);
                lane    = (old >> sh) & 32'hFF;
                e_rdata = (u || lane < 128) ? lane : lane + 32'hFFFF_FF00;
                e_word  = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end
            2'b01: begin
                sh      = 16 * (1 - (a % 4) / 2);
                lane    = (old >> sh) & 32'hFFFF;
                e_rdata = (u || lane < 32768) ? lane : lane + 32'hFFFF_0000;
                e_word  = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            default: begin
                e_rdata = old;
                e_word  = wd;
            end
        endcase
        if (w || e_fault) e_rdata = '0;
        e_lat  = e_fault ? 1 : ((w && sz != 2'b11) ? 3 : 2);
        e_rd   = (!e_fault && (!w || sz != 2'b11)) ? 1 : 0;
        e_wr   = (!e_fault && w) ? 1 : 0;
        e_wcyc = (sz == 2'b11) ? 1 : 2;

        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        wt = 0;
        while (!req_ready && wt < 8) begin
            @(negedge clock);
            wt++;
        end
        last_wait = wt;
        check("accept_ready", req_ready, 1'b1);
        @(posedge clock);

        lat = 0; n_rd = 0; n_wr = 0; w_cyc = 0;
        w_addr = '0; w_data = '0; r_addr = '0;
        for (int unsigned k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) begin
                last_acc = cyc;
                if (keep) begin
                    req_write    = 1'($urandom);
                    req_size     = 2'($urandom);
                    req_unsigned = 1'($urandom);
                    req_addr     = $urandom;
                    req_wdata    = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (mem_read_enable) begin
                n_rd++;
                r_addr = mem_address;
            end
            if (mem_write_enable) begin
                n_wr++;
                w_cyc  = k;
                w_addr = mem_address;
                w_data = mem_write_data;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end

        check("latency", lat, e_lat);
        check("fault", resp_fault, e_fault);
        check("rdata", resp_rdata, e_rdata);
        check("rd_count", n_rd, e_rd);
        check("wr_count", n_wr, e_wr);
        if (e_wr != 0) begin
            check("wr_cycle", w_cyc, e_wcyc);
            check("wr_addr", w_addr, idx);
            check("wr_data", w_data, e_word);
        end
        if (e_rd != 0) check("rd_addr", r_addr, idx);
        if (!e_fault && w) ref_mem[idx[IW-1:0]] = e_word;
        if (idx < MW) check("mem_word", mem[idx[IW-1:0]], ref_mem[idx[IW-1:0]]);

        if (!keep) begin
            @(negedge clock);
            check("hold_rdata", resp_rdata, e_rdata);
            check("hold_fault", resp_fault, e_fault);
            check("idle_ready", req_ready, 1'b1);
            check("idle_resp", resp_valid, 1'b0);
        end
    endtask

    initial begin
        int unsigned acc1, r;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          kp;

        for (int unsigned i = 0; i < MW; i++) ref_mem[i] = '0;
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_fault", resp_fault, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_re", mem_read_enable, 1'b0);
        check("rst_mem_we", mem_write_enable, 1'b0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        reset_n = 1'b1;
        #1 check("rst_ready", req_ready, 1'b1);
        @(negedge clock);

        // word store then load
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        check("tp_lw", resp_rdata, 32'hDEAD_BEEF);

        // sub-word load extension
        do_req(1'b1, 2'b11, 1'b0, 32'h0C, 32'h12F4_5678, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 1'b0);
        check("tp_lb", resp_rdata, 32'hFFFF_FFF4);
        do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 1'b0);
        check("tp_lbu", resp_rdata, 32'h0000_00F4);
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 1'b0);
        check("tp_lh", resp_rdata, 32'h0000_5678);

        // sub-word read-modify-write
        do_req(1'b1, 2'b11, 1'b0, 32'h08, 32'hAABB_CCDD, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h0A, 32'h0000_0011, 1'b0);
        check("tp_sb_word", mem[2], 32'hAABB_11DD);
        do_req(1'b1, 2'b01, 1'b0, 32'h08, 32'h0000_2233, 1'b0);
        check("tp_sh_word", mem[2], 32'h2233_11DD);

        // misalignment and reserved size
        do_req(1'b0, 2'b11, 1'b0, 32'h06, 32'h0, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h5555_5555, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);

        // range boundary: index 128 faults or wraps to word 0
        do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h1FC, 32'h0, 1'b0);

        // back-to-back: second request held while busy, accepted in the first IDLE cycle
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1);
        acc1 = last_acc;
        do_req(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 1'b0);
        check("b2b_gap", last_acc - acc1, 3);
        check("b2b_wait", last_wait, 1);

        // reset during MERGE_WRITE of a byte store
        do_req(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0D; req_wdata = 32'h0000_0099;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("mw_we_before_rst", mem_write_enable, 1'b1);
        reset_n = 1'b0;
        #1 check("mw_we_gated", mem_write_enable, 1'b0);
        @(negedge clock);
        check("mw_rst_resp", resp_valid, 1'b0);
        check("mw_rst_rdata", resp_rdata, 32'h0);
        reset_n = 1'b1;
        #1 check("mw_rst_ready", req_ready, 1'b1);
        @(negedge clock);
        check("mw_no_resp", resp_valid, 1'b0);
        check("mw_mem_kept", mem[3], ref_mem[3]);

        // random traffic
        for (int unsigned n = 0; n < 300; n++) begin
            sz = 2'($urandom);
            r  = $urandom_range(0, 19);
            if (r < 14)      a = $urandom_range(0, 4 * MW - 1);
            else if (r < 19) a = $urandom_range(0, 8 * MW - 1);
            else             a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b11)      a = a & ~32'h3;
                else if (sz == 2'b01) a = a & ~32'h1;
            end
            kp = (n != 299) && ($urandom_range(0, 1) == 1);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, kp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end placed directly upstream of the word-wide data memory. Takes byte-addressed MIPS load/store requests from the execute stage, converts them to word-indexed memory accesses, and performs sign/zero extension for sub-word loads. Sub-word stores are done as a read-modify-write sequence, because the memory only writes whole words. It also flags misaligned or out-of-range accesses.

## Interface

Parameters:
- MEM_WORDS, 128: number of 32-bit words in the data memory; the range limit for the range check.

Ports:
- clock  in  1  rising-edge clock shared with data memory
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 11 word, 10 reserved
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid: access was rejected
- mem_address  out  32  word index to memory, {2'b0, addr[31:2]}
- mem_write_data  out  32  word to write
- mem_write_enable  out  1  memory write strobe
- mem_read_enable  out  1  memory read enable
- mem_out  in  32  combinational read data from memory

## Operation

- **States:** IDLE, ACCESS, MERGE_WRITE, RESP.
- **IDLE**
  - req_ready = 1.
  - When req_valid is high, latch write, size, unsigned, addr and wdata.
  - If the request faults, go to RESP with the fault flag set and make no memory access; otherwise go to ACCESS.
- **Fault conditions**
  - req_size = 10.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] ≠ 00.
  - Range violation, per Configuration.
- **ACCESS**
  - mem_address = latched word index.
  - Load: assert mem_read_enable; extract the lane from mem_out, extend it, register it into resp_rdata; go to RESP.
  - Word store: assert mem_write_enable with mem_write_data = wdata; go to RESP.
  - Sub-word store: assert mem_read_enable; register the merged word (mem_out with the target lane replaced); go to MERGE_WRITE.
- **MERGE_WRITE:** assert mem_write_enable with the merged word at the same mem_address; go to RESP.
- **RESP:** resp_valid = 1 for exactly one cycle; go to IDLE.
- **Byte order is big-endian.**
  - Byte lanes: addr[1:0] = 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Halfword lanes: addr[1] = 0 → [31:16], 1 → [15:0].
- **Extension:** the sign bit is the MSB of the extracted lane. Word loads pass through unchanged; req_unsigned is ignored for words.
- **Idle memory outputs:** outside ACCESS and MERGE_WRITE, mem_read_enable = mem_write_enable = 0, and mem_address = mem_write_data = 0.
- **Requests while busy:** req_valid while req_ready = 0 is ignored. The requester holds the request until it is accepted.

## Timing

- Request accepted at edge T (state IDLE, req_valid = 1).
- Load: ACCESS in T+1, resp_valid in T+2. Three cycles from acceptance to the next possible acceptance.
- Word store: memory written at the end of T+1, resp_valid in T+2.
- Sub-word store: read in T+1, write at the end of T+2, resp_valid in T+3.
- Fault: RESP in T+1 with resp_fault = 1 and resp_rdata = 0; no mem enable is ever asserted.
- **Reset values** (after any clock edge with reset_n = 0):
  - State IDLE, so req_ready = 1 once reset_n is high.
  - resp_valid, resp_fault, mem_read_enable and mem_write_enable are 0.
  - resp_rdata, mem_address and mem_write_data are 0.
- **Reset mid-operation:** aborts the access.
  - A reset in ACCESS or MERGE_WRITE suppresses any write that had not yet reached an edge.
  - No resp_valid is produced for the aborted request.
- **Value hold:** resp_rdata and resp_fault hold their value until the next RESP.

## Configuration

- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- **Defined:** a word index addr[31:2] ≥ MEM_WORDS is a fault, handled like a misalignment.
- **Undefined:** no range fault. mem_address = addr[31:2] mod MEM_WORDS (upper bits zeroed); only the alignment and size faults remain.

## Test plan

- **Word store then word load.**
  - Store 0xDEADBEEF to addr 0x10: mem_address = 4, write in T+1, resp in T+2.
  - Word load from 0x10 then returns 0xDEADBEEF in T+2.
- **Byte load extension.** Word 3 = 0x12F45678.
  - lb at 0x0D → 0xFFFFFFF4.
  - lbu at 0x0D → 0x000000F4.
  - lh at 0x0E → 0x00005678.
- **Sub-word store read-modify-write.** Word 2 = 0xAABBCCDD.
  - sb 0x11 at addr 0x0A → memory word 2 = 0xAABB11DD; resp in T+3; exactly one write pulse, in T+2.
  - sh 0x2233 at 0x08 → 0x223311DD.
- **Misalignment faults.**
  - lw at 0x06 and sh at 0x03 → resp_fault = 1 in T+1, resp_rdata = 0, no mem enables asserted, memory unchanged.
- **Range check.** Word load from 0x200 (index 128):
  - With the macro: fault.
  - Without the macro: reads word 0.
- **Reset mid-operation.**
  - Assert reset_n = 0 during MERGE_WRITE of an sb: memory unchanged, no resp_valid, req_ready = 1 after release.
  - Back-to-back requests held while busy are accepted only in IDLE.
